// File: rtl/powlib_busfifo_if.sv
// Address/data beat channel with valid/ready handshake and a not-nearly-full hint.
// The producer drives the master modport; the consumer takes the slave modport.
interface powlib_busfifo_if #(
  parameter int B_AW = 32,
  parameter int B_DW = 32
);
  logic [B_AW-1:0] addr;
  logic [B_DW-1:0] data;
  logic            vld;
  logic            rdy;
  logic            nf;

  modport master (output addr, output data, output vld, input  rdy, input  nf);
  modport slave  (input  addr, input  data, input  vld, output rdy, output nf);
endinterface

// File: rtl/powlib_busfifo.sv
// Single-clock first-word-fall-through FIFO of {addr,data} beats, any depth D >= 2.
// Define POWLIB_BUSFIFO_DBG_EN to compile in push/pop/overflow trace messages.
module powlib_busfifo #(
  parameter string ID   = "BUSFIFO",
  parameter int    NFS  = 0,
  parameter int    D    = 8,
  parameter int    B_AW = 32,
  parameter int    B_DW = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  powlib_busfifo_if.slave       wr,
  powlib_busfifo_if.master      rd
);
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);

  if (D < 2 || NFS >= D) begin : g_bad_cfg
    $fatal(1, "%s: illegal configuration D=%0d NFS=%0d", ID, D, NFS);
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_fire, rd_fire;
  logic          full, empty;

  logic [B_AW+B_DW-1:0] mem_q [D];

  // Status flags come straight from the count register, never from vld/rdy.
  assign full   = (count_q == CW'(D));
  assign empty  = (count_q == '0);
  assign wr.rdy = ~full;
  assign wr.nf  = (int'(count_q) + NFS) < D;
  assign rd.vld = ~empty;

  assign {rd.addr, rd.data} = mem_q[rd_ptr_q];

  always_comb begin
    wr_fire  = wr.vld & ~full;
    rd_fire  = rd.rdy & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = (wr_ptr_q == PW'(D - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (rd_fire) rd_ptr_d = (rd_ptr_q == PW'(D - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left out of reset; rdvld masks stale entries.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= {wr.addr, wr.data};
  end

`ifdef POWLIB_BUSFIFO_DBG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      if (wr_fire)
        $display("%s WR addr=%0h data=%0h count=%0d", ID, wr.addr, wr.data, count_q);
      if (rd_fire)
        $display("%s RD addr=%0h data=%0h count=%0d", ID, rd.addr, rd.data, count_q);
      if (wr.vld && full)
        $display("%s OVF", ID);
    end
  end
`endif

endmodule

// File: tb/tb_powlib_busfifo.sv
// Directed bench for powlib_busfifo (D=8, NFS=3) with a queue-based reference model.
module tb_powlib_busfifo;
  localparam int D = 8, NFS = 3, AW = 32, DW = 32;

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [AW-1:0] wraddr = '0;
  logic [DW-1:0] wrdata = '0;
  logic wrvld = 1'b0, rdrdy = 1'b0;
  int errors = 0, checks = 0;
  bit started = 1'b0;
  beat_t q[$];

  always #5 clk = ~clk;

  powlib_busfifo_if #(.B_AW(AW), .B_DW(DW)) wr_if ();
  powlib_busfifo_if #(.B_AW(AW), .B_DW(DW)) rd_if ();

  assign wr_if.addr = wraddr;
  assign wr_if.data = wrdata;
  assign wr_if.vld  = wrvld;
  assign rd_if.rdy  = rdrdy;
  assign rd_if.nf   = 1'b1;

  powlib_busfifo #(.ID("BUSFIFO"), .NFS(NFS), .D(D), .B_AW(AW), .B_DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .wr  (wr_if.slave),
    .rd  (rd_if.master)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a plain queue, updated from the pre-edge inputs.
  always @(posedge clk or negedge rst) begin
    if (!rst) q.delete();
    else begin
      automatic bit push = wrvld && (q.size() < D);
      automatic bit pop  = rdrdy && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{a: wraddr, d: wrdata});
    end
  end

  always @(negedge clk) begin
    if (started && rst) begin
      chk("m_rdvld", rd_if.vld, q.size() != 0);
      chk("m_wrrdy", wr_if.rdy, q.size() != D);
      chk("m_wrnf",  wr_if.nf,  (q.size() + NFS) < D);
      if (q.size() != 0) begin
        chk("m_rdaddr", rd_if.addr, q[0].a);
        chk("m_rddata", rd_if.data, q[0].d);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    started = 1'b1;
    chk("rst_rdvld", rd_if.vld, 0);
    chk("rst_wrrdy", wr_if.rdy, 1);
    chk("rst_wrnf",  wr_if.nf,  1);

    // asynchronous reset mid-cycle
    wraddr = 32'h1; wrdata = 32'h2; wrvld = 1'b1;
    cyc();
    wrvld = 1'b0;
    chk("async_pre_rdvld", rd_if.vld, 1);
    #2 rst = 1'b0;
    #1 chk("async_rdvld", rd_if.vld, 0);
    chk("async_wrrdy", wr_if.rdy, 1);
    cyc();
    rst = 1'b1;

    // fill to full with NFS=3
    wrvld = 1'b1;
    for (int i = 0; i < D; i++) begin
      wraddr = i; wrdata = 32'hA0 + i;
      cyc();
      if (i == 3) chk("fill_nf4", wr_if.nf, 1);
      if (i == 4) chk("fill_nf5", wr_if.nf, 0);
      if (i == 6) chk("fill_rdy7", wr_if.rdy, 1);
      if (i == 7) chk("fill_rdy8", wr_if.rdy, 0);
    end
    wraddr = 32'h8; wrdata = 32'hA8;
    cyc();
    chk("ovf_wrrdy", wr_if.rdy, 0);
    chk("ovf_head", rd_if.addr, 0);
    wrvld = 1'b0;

    // drain in order
    rdrdy = 1'b1;
    for (int i = 0; i < D; i++) begin
      chk("drain_vld",  rd_if.vld, 1);
      chk("drain_addr", rd_if.addr, i);
      chk("drain_data", rd_if.data, 32'hA0 + i);
      cyc();
      if (i == 2) chk("drain_nf5", wr_if.nf, 0);
      if (i == 3) chk("drain_nf4", wr_if.nf, 1);
    end
    chk("drain_empty", rd_if.vld, 0);
    rdrdy = 1'b0;

    // push into empty: visible one cycle later
    wraddr = 32'h10; wrdata = 32'h55; wrvld = 1'b1;
    cyc();
    wrvld = 1'b0;
    chk("fwft_vld",  rd_if.vld, 1);
    chk("fwft_addr", rd_if.addr, 32'h10);
    chk("fwft_data", rd_if.data, 32'h55);
    rdrdy = 1'b1;
    cyc();
    rdrdy = 1'b0;
    chk("fwft_pop", rd_if.vld, 0);

    // streaming 100 beats, push and pop every cycle
    wrvld = 1'b1; rdrdy = 1'b1;
    for (int k = 0; k < 100; k++) begin
      wraddr = 100 + k; wrdata = k * 3;
      cyc();
      chk("stream_head", rd_if.addr, 100 + k);
      chk("stream_data", rd_if.data, k * 3);
    end
    wrvld = 1'b0;
    cyc();
    rdrdy = 1'b0;
    chk("stream_empty", rd_if.vld, 0);

    // full plus simultaneous pop: write rejected, accepted next cycle
    wrvld = 1'b1;
    for (int i = 0; i < D; i++) begin
      wraddr = 32'h200 + i; wrdata = i;
      cyc();
    end
    chk("full6_rdy", wr_if.rdy, 0);
    wraddr = 32'h300; wrdata = 32'h77; rdrdy = 1'b1;
    cyc();
    rdrdy = 1'b0;
    chk("full6_after_rdy", wr_if.rdy, 1);
    chk("full6_head", rd_if.addr, 32'h201);
    cyc();
    wrvld = 1'b0;
    chk("full6_refull", wr_if.rdy, 0);
    rdrdy = 1'b1;
    repeat (7) cyc();
    chk("full6_last_addr", rd_if.addr, 32'h300);
    chk("full6_last_data", rd_if.data, 32'h77);
    cyc();
    rdrdy = 1'b0;
    chk("full6_empty", rd_if.vld, 0);

    repeat (2) cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
